// File: rtl/piece_move_gen.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : piece_move_gen                                               |
// | Description : Sequential pseudo-legal move generator for knight, bishop,   |
// |               rook, queen and king. Snapshots a piece and the board,       |
// |               walks the direction table one candidate per cycle and        |
// |               streams targets over a valid/ready handshake, finishing      |
// |               with a done pulse, move count and type-error flag.           |
// | Options     : PIECE_MOVE_GEN_ATTACK_MASK_EN adds the attackMask output.    |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module piece_move_gen #(
    parameter int BOARD_N = 8,
    parameter int COORD_W = $clog2(BOARD_N),
    parameter int CNT_W   = 6
) (
    input  logic                         clk,
    input  logic                         resetN,
    input  logic                         start,
    input  logic [COORD_W-1:0]           row,
    input  logic [COORD_W-1:0]           column,
    input  logic                         color,
    input  logic [2:0]                   pieceType,
    input  logic [5*BOARD_N*BOARD_N-1:0] boardFlat,
    output logic                         busy,
    output logic                         moveValid,
    input  logic                         moveReady,
    output logic [COORD_W-1:0]           moveRow,
    output logic [COORD_W-1:0]           moveCol,
    output logic                         moveCapture,
    output logic                         done,
    output logic [CNT_W-1:0]             moveCount,
`ifdef PIECE_MOVE_GEN_ATTACK_MASK_EN
    output logic [BOARD_N*BOARD_N-1:0]   attackMask,
`endif
    output logic                         typeError
);

    localparam int NSQ   = BOARD_N * BOARD_N;
    localparam int IDX_W = $clog2(NSQ);
    localparam int CW2   = COORD_W + 2;

    typedef logic signed [CW2-1:0] scoord_t;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SCAN = 2'd1,
        S_EMIT = 2'd2,
        S_DONE = 2'd3
    } state_t;

    // Offsets are packed as {drow[2:0], dcol[2:0]} in two's complement.
    function automatic logic [5:0] knight_off(input logic [2:0] d);
        logic [5:0] o;
        case (d)
            3'd0:    o = {3'b110, 3'b111}; // (-2,-1)
            3'd1:    o = {3'b110, 3'b001}; // (-2,+1)
            3'd2:    o = {3'b111, 3'b010}; // (-1,+2)
            3'd3:    o = {3'b001, 3'b010}; // (+1,+2)
            3'd4:    o = {3'b010, 3'b001}; // (+2,+1)
            3'd5:    o = {3'b010, 3'b111}; // (+2,-1)
            3'd6:    o = {3'b001, 3'b110}; // (+1,-2)
            default: o = {3'b111, 3'b110}; // (-1,-2)
        endcase
        return o;
    endfunction

    function automatic logic [5:0] rook_off(input logic [1:0] d);
        logic [5:0] o;
        case (d)
            2'd0:    o = {3'b111, 3'b000}; // (-1, 0)
            2'd1:    o = {3'b000, 3'b001}; // ( 0,+1)
            2'd2:    o = {3'b001, 3'b000}; // (+1, 0)
            default: o = {3'b000, 3'b111}; // ( 0,-1)
        endcase
        return o;
    endfunction

    function automatic logic [5:0] bishop_off(input logic [1:0] d);
        logic [5:0] o;
        case (d)
            2'd0:    o = {3'b111, 3'b111}; // (-1,-1)
            2'd1:    o = {3'b111, 3'b001}; // (-1,+1)
            2'd2:    o = {3'b001, 3'b001}; // (+1,+1)
            default: o = {3'b001, 3'b111}; // (+1,-1)
        endcase
        return o;
    endfunction

    function automatic logic [5:0] queen_off(input logic [2:0] d);
        logic [5:0] o;
        case (d)
            3'd0:    o = {3'b111, 3'b000}; // (-1, 0)
            3'd1:    o = {3'b111, 3'b001}; // (-1,+1)
            3'd2:    o = {3'b000, 3'b001}; // ( 0,+1)
            3'd3:    o = {3'b001, 3'b001}; // (+1,+1)
            3'd4:    o = {3'b001, 3'b000}; // (+1, 0)
            3'd5:    o = {3'b001, 3'b111}; // (+1,-1)
            3'd6:    o = {3'b000, 3'b111}; // ( 0,-1)
            default: o = {3'b111, 3'b111}; // (-1,-1)
        endcase
        return o;
    endfunction

    // Request snapshot and scan position
    state_t               state_q;
    logic [COORD_W-1:0]   row_q;
    logic [COORD_W-1:0]   col_q;
    logic                 color_q;
    logic [2:0]           ptype_q;
    logic [1:0]           board_q [NSQ];
    logic [2:0]           dir_q;
    logic [COORD_W:0]     step_q;
    logic                 term_q;

    // Registered outputs
    logic                 busy_q;
    logic                 valid_q;
    logic [COORD_W-1:0]   mrow_q;
    logic [COORD_W-1:0]   mcol_q;
    logic                 mcap_q;
    logic                 done_q;
    logic [CNT_W-1:0]     count_q;
    logic                 terr_q;

    // Candidate evaluation
    logic                 w_slider;
    logic                 w_supported;
    logic [2:0]           w_last_dir;
    logic [5:0]           w_off;
    scoord_t              w_dr;
    scoord_t              w_dc;
    scoord_t              w_mul;
    scoord_t              w_cand_r;
    scoord_t              w_cand_c;
    logic                 w_onboard;
    logic [COORD_W-1:0]   w_tr;
    logic [COORD_W-1:0]   w_tc;
    logic [IDX_W-1:0]     w_idx;
    logic [1:0]           w_sq;
    logic                 w_blocked;
    logic                 w_last;
    logic                 w_handshake;

    // Only occupancy and colour matter for move generation; type bits are dropped.
    logic                 w_unused_bits;
    assign w_unused_bits = ^boardFlat;

    // Select the direction table and its length from the captured piece type.
    always_comb begin
        w_slider    = 1'b0;
        w_supported = 1'b1;
        w_last_dir  = 3'd7;
        w_off       = 6'b0;
        case (ptype_q)
            3'b010: w_off = knight_off(dir_q);
            3'b011: begin
                w_slider   = 1'b1;
                w_last_dir = 3'd3;
                w_off      = bishop_off(dir_q[1:0]);
            end
            3'b100: begin
                w_slider   = 1'b1;
                w_last_dir = 3'd3;
                w_off      = rook_off(dir_q[1:0]);
            end
            3'b101: begin
                w_slider = 1'b1;
                w_off    = queen_off(dir_q);
            end
            3'b110: w_off = queen_off(dir_q);
            default: w_supported = 1'b0;
        endcase
    end

    // Candidate = origin + (step+1)*offset, in signed arithmetic so that
    // stepping off any edge is detected instead of wrapping.
    assign w_dr      = {{(CW2-3){w_off[5]}}, w_off[5:3]};
    assign w_dc      = {{(CW2-3){w_off[2]}}, w_off[2:0]};
    assign w_mul     = scoord_t'({1'b0, step_q}) + scoord_t'(1);
    assign w_cand_r  = scoord_t'({2'b00, row_q}) + w_mul * w_dr;
    assign w_cand_c  = scoord_t'({2'b00, col_q}) + w_mul * w_dc;
    assign w_onboard = (w_cand_r >= 0) && (w_cand_r < scoord_t'(BOARD_N)) &&
                       (w_cand_c >= 0) && (w_cand_c < scoord_t'(BOARD_N));
    assign w_tr      = w_cand_r[COORD_W-1:0];
    assign w_tc      = w_cand_c[COORD_W-1:0];
    assign w_idx     = w_onboard ? (IDX_W'(w_tr) * IDX_W'(BOARD_N) + IDX_W'(w_tc)) : '0;
    assign w_sq      = board_q[w_idx];
    assign w_blocked = !w_onboard || (w_sq[0] && (w_sq[1] == color_q));
    assign w_last    = (dir_q == w_last_dir);
    assign w_handshake = valid_q && moveReady;

`ifdef PIECE_MOVE_GEN_ATTACK_MASK_EN
    logic [NSQ-1:0]       mask_q;
    logic [IDX_W-1:0]     w_tidx;
    assign w_tidx     = IDX_W'(mrow_q) * IDX_W'(BOARD_N) + IDX_W'(mcol_q);
    assign attackMask = mask_q;
`endif

    // Capture the board occupancy/colour snapshot when a request is accepted.
    always_ff @(posedge clk) begin
        if (state_q == S_IDLE && start) begin
            for (int i = 0; i < NSQ; i++) begin
                board_q[i] <= boardFlat[i*5 +: 2];
            end
        end
    end

    // Main scan FSM with registered handshake and status outputs.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state_q <= S_IDLE;
            row_q   <= '0;
            col_q   <= '0;
            color_q <= 1'b0;
            ptype_q <= 3'b0;
            dir_q   <= 3'd0;
            step_q  <= '0;
            term_q  <= 1'b0;
            busy_q  <= 1'b0;
            valid_q <= 1'b0;
            mrow_q  <= '0;
            mcol_q  <= '0;
            mcap_q  <= 1'b0;
            done_q  <= 1'b0;
            count_q <= '0;
            terr_q  <= 1'b0;
`ifdef PIECE_MOVE_GEN_ATTACK_MASK_EN
            mask_q  <= '0;
`endif
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        row_q   <= row;
                        col_q   <= column;
                        color_q <= color;
                        ptype_q <= pieceType;
                        dir_q   <= 3'd0;
                        step_q  <= '0;
                        term_q  <= 1'b0;
                        count_q <= '0;
                        terr_q  <= 1'b0;
                        busy_q  <= 1'b1;
                        state_q <= S_SCAN;
`ifdef PIECE_MOVE_GEN_ATTACK_MASK_EN
                        mask_q  <= '0;
`endif
                    end
                end
                S_SCAN: begin
                    if (!w_supported) begin
                        terr_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= S_DONE;
                    end else if (w_blocked) begin
                        // Nothing reachable further along this ray.
                        if (w_last) begin
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            state_q <= S_DONE;
                        end else begin
                            dir_q  <= dir_q + 3'd1;
                            step_q <= '0;
                            term_q <= 1'b0;
                        end
                    end else begin
                        mrow_q  <= w_tr;
                        mcol_q  <= w_tc;
                        mcap_q  <= w_sq[0];
                        term_q  <= w_sq[0];
                        valid_q <= 1'b1;
                        state_q <= S_EMIT;
                    end
                end
                S_EMIT: begin
                    if (w_handshake) begin
                        valid_q <= 1'b0;
                        if (count_q != {CNT_W{1'b1}}) begin
                            count_q <= count_q + 1'b1;
                        end
`ifdef PIECE_MOVE_GEN_ATTACK_MASK_EN
                        mask_q[w_tidx] <= 1'b1;
`endif
                        if (w_slider && !term_q) begin
                            step_q  <= step_q + 1'b1;
                            state_q <= S_SCAN;
                        end else if (w_last) begin
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            state_q <= S_DONE;
                        end else begin
                            dir_q   <= dir_q + 3'd1;
                            step_q  <= '0;
                            term_q  <= 1'b0;
                            state_q <= S_SCAN;
                        end
                    end
                end
                default: begin
                    // DONE lasts exactly one cycle; start is not looked at here.
                    done_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign busy        = busy_q;
    assign moveValid   = valid_q;
    assign moveRow     = mrow_q;
    assign moveCol     = mcol_q;
    assign moveCapture = mcap_q;
    assign done        = done_q;
    assign moveCount   = count_q;
    assign typeError   = terr_q;

endmodule
`default_nettype wire

// File: tb/tb_piece_move_gen.sv
`timescale 1ns/1ps
module tb_piece_move_gen;

    localparam int N  = 8;
    localparam int BW = 5 * N * N;

    logic          clk = 1'b0;
    logic          resetN = 1'b0;
    logic          start = 1'b0;
    logic [2:0]    row = '0;
    logic [2:0]    column = '0;
    logic          color = 1'b0;
    logic [2:0]    pieceType = '0;
    logic [BW-1:0] boardFlat = '0;
    logic          moveReady = 1'b0;
    logic          busy;
    logic          moveValid;
    logic [2:0]    moveRow;
    logic [2:0]    moveCol;
    logic          moveCapture;
    logic          done;
    logic [5:0]    moveCount;
    logic          typeError;
`ifdef PIECE_MOVE_GEN_ATTACK_MASK_EN
    logic [N*N-1:0] attackMask;
`endif

    piece_move_gen #(.BOARD_N(N), .COORD_W(3), .CNT_W(6)) dut (
        .clk(clk), .resetN(resetN), .start(start), .row(row), .column(column),
        .color(color), .pieceType(pieceType), .boardFlat(boardFlat),
        .busy(busy), .moveValid(moveValid), .moveReady(moveReady),
        .moveRow(moveRow), .moveCol(moveCol), .moveCapture(moveCapture),
        .done(done), .moveCount(moveCount),
`ifdef PIECE_MOVE_GEN_ATTACK_MASK_EN
        .attackMask(attackMask),
`endif
        .typeError(typeError)
    );

    always #5 clk = ~clk;

    typedef struct { int r; int c; bit cap; } mv_t;

    mv_t          exp_q[$];
    mv_t          obs_q[$];
    logic [63:0]  exp_mask;
    int           n_tot = 0;
    int           n_bad = 0;
    int           first_valid_cyc;
    int           done_cyc;
    int           last_count;
    int           last_te;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] want);
        n_tot++;
        if (act !== want) begin
            n_bad++;
            $display("FAIL %s: got %0d want %0d", nm, act, want);
        end
    endtask

    function automatic logic [BW-1:0] put(input logic [BW-1:0] b, input int r, input int c,
                                          input bit col, input logic [2:0] t);
        b[(r*N+c)*5 +: 5] = {t, col, 1'b1};
        return b;
    endfunction

    // Reference: walk each ray of the piece over the board with plain loops.
    task automatic build_exp(input int pr, input int pc, input bit pcol, input logic [2:0] pt,
                             input logic [BW-1:0] b);
        int dr[8];
        int dc[8];
        int nd;
        bit slide;
        int r;
        int c;
        logic [4:0] sq;
        mv_t m;
        exp_q.delete();
        exp_mask = '0;
        nd = 0;
        slide = 0;
        dr = '{0, 0, 0, 0, 0, 0, 0, 0};
        dc = '{0, 0, 0, 0, 0, 0, 0, 0};
        case (pt)
            3'd2: begin dr = '{-2, -2, -1, 1, 2, 2, 1, -1}; dc = '{-1, 1, 2, 2, 1, -1, -2, -2}; nd = 8; end
            3'd3: begin dr = '{-1, -1, 1, 1, 0, 0, 0, 0}; dc = '{-1, 1, 1, -1, 0, 0, 0, 0}; nd = 4; slide = 1; end
            3'd4: begin dr = '{-1, 0, 1, 0, 0, 0, 0, 0}; dc = '{0, 1, 0, -1, 0, 0, 0, 0}; nd = 4; slide = 1; end
            3'd5: begin dr = '{-1, -1, 0, 1, 1, 1, 0, -1}; dc = '{0, 1, 1, 1, 0, -1, -1, -1}; nd = 8; slide = 1; end
            3'd6: begin dr = '{-1, -1, 0, 1, 1, 1, 0, -1}; dc = '{0, 1, 1, 1, 0, -1, -1, -1}; nd = 8; end
            default: nd = 0;
        endcase
        for (int d = 0; d < nd; d++) begin
            for (int k = 1; k <= N; k++) begin
                r = pr + k * dr[d];
                c = pc + k * dc[d];
                if (r < 0 || r >= N || c < 0 || c >= N) break;
                sq = b[(r*N+c)*5 +: 5];
                if (sq[0] && sq[1] == pcol) break;
                m.r = r;
                m.c = c;
                m.cap = sq[0];
                exp_q.push_back(m);
                exp_mask[r*N+c] = 1'b1;
                if (sq[0] || !slide) break;
            end
        end
    endtask

    task automatic run_req(input int pr, input int pc, input bit pcol, input logic [2:0] pt,
                           input logic [BW-1:0] b, input int rdy_pct, input int stall_first,
                           input int abort_cyc, input bit poke_busy, input bit poke_done);
        int cyc;
        bit seen;
        int stall;
        int nexp;
        int te_exp;
        mv_t m;
        build_exp(pr, pc, pcol, pt, b);
        nexp = exp_q.size();
        if (nexp > 63) nexp = 63;
        te_exp = (pt >= 3'd2 && pt <= 3'd6) ? 0 : 1;
        obs_q.delete();
        first_valid_cyc = -1;
        done_cyc = -1;
        @(negedge clk);
        start = 1'b1;
        row = pr[2:0];
        column = pc[2:0];
        color = pcol;
        pieceType = pt;
        boardFlat = b;
        moveReady = 1'b0;
        @(negedge clk);
        cyc = 1;
        seen = 0;
        stall = stall_first;
        while (!seen && cyc < 3000) begin
            start = (poke_busy && cyc == 1);
            if (cyc == 1) begin
                row = 3'($urandom);
                column = 3'($urandom);
                color = 1'($urandom);
                pieceType = 3'($urandom);
                boardFlat = {10{$urandom}};
            end
            if (cyc == abort_cyc) begin
                resetN = 1'b0;
                #1;
                chk("abort_outputs_zero",
                    {busy, moveValid, moveRow, moveCol, moveCapture, done, moveCount, typeError}, 0);
`ifdef PIECE_MOVE_GEN_ATTACK_MASK_EN
                chk("abort_mask_zero", attackMask, 0);
`endif
                moveReady = 1'b0;
                start = 1'b0;
                @(negedge clk);
                resetN = 1'b1;
                for (int i = 0; i < 6; i++) begin
                    @(negedge clk);
                    chk("abort_no_done", done, 0);
                    chk("abort_not_busy", busy, 0);
                end
                return;
            end
            if (done) begin
                seen = 1;
                done_cyc = cyc;
                last_count = moveCount;
                last_te = typeError;
                chk("done_queue_empty", exp_q.size(), 0);
                chk("done_count", moveCount, nexp);
                chk("done_type_error", typeError, te_exp);
                chk("done_busy_low", busy, 0);
                chk("done_valid_low", moveValid, 0);
`ifdef PIECE_MOVE_GEN_ATTACK_MASK_EN
                chk("done_mask", attackMask, exp_mask);
`endif
            end else begin
                chk("busy_high", busy, 1);
                if (moveValid) begin
                    if (first_valid_cyc < 0) first_valid_cyc = cyc;
                    if (exp_q.size() == 0) chk("extra_move", moveValid, 0);
                    else chk("move_r_c_cap",
                             int'(moveRow) * 100 + int'(moveCol) * 10 + int'(moveCapture),
                             exp_q[0].r * 100 + exp_q[0].c * 10 + int'(exp_q[0].cap));
                    if (stall > 0) begin
                        moveReady = 1'b0;
                        stall--;
                    end else begin
                        moveReady = ($urandom_range(99) < rdy_pct);
                    end
                    if (moveReady) begin
                        m.r = moveRow;
                        m.c = moveCol;
                        m.cap = moveCapture;
                        obs_q.push_back(m);
                        if (exp_q.size() > 0) void'(exp_q.pop_front());
                    end
                end else begin
                    moveReady = 1'($urandom);
                end
                @(negedge clk);
                cyc++;
            end
        end
        if (!seen) chk("timeout_no_done", 0, 1);
        start = poke_done;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            start = 1'b0;
            chk("idle_no_done", done, 0);
            chk("idle_not_busy", busy, 0);
            chk("idle_count_held", moveCount, nexp);
        end
    endtask

    logic [BW-1:0] bd;

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        resetN = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("reset_outputs_zero",
            {busy, moveValid, moveRow, moveCol, moveCapture, done, moveCount, typeError}, 0);
        resetN = 1'b1;

        // White knight in the corner on an empty board.
        run_req(0, 0, 0, 3'b010, '0, 100, 0, -1, 0, 0);
        chk("knight00_n", obs_q.size(), 2);
        chk("knight00_m0", obs_q[0].r * 10 + obs_q[0].c, 12);
        chk("knight00_m1", obs_q[1].r * 10 + obs_q[1].c, 21);
        chk("knight00_cap", {obs_q[0].cap, obs_q[1].cap}, 0);
        chk("knight00_count", last_count, 2);
        chk("knight00_te", last_te, 0);

        // White rook blocked by a black piece (capture) and a white piece.
        bd = '0;
        bd = put(bd, 7, 0, 0, 3'b100);
        bd = put(bd, 5, 0, 1, 3'b010);
        bd = put(bd, 7, 3, 0, 3'b011);
        run_req(7, 0, 0, 3'b100, bd, 100, 0, -1, 0, 0);
        chk("rook_n", obs_q.size(), 4);
        chk("rook_m1", obs_q[1].r * 100 + obs_q[1].c * 10 + int'(obs_q[1].cap), 501);
        chk("rook_m3", obs_q[3].r * 10 + obs_q[3].c, 72);
        chk("rook_count", last_count, 4);

        // Queen in the middle, random back-pressure, start poked in the done cycle.
        run_req(3, 3, 1, 3'b101, '0, 50, 0, -1, 0, 1);
        chk("queen_n", obs_q.size(), 27);
        chk("queen_first", obs_q[0].r * 10 + obs_q[0].c, 23);
        chk("queen_last", obs_q[26].r * 10 + obs_q[26].c, 0);
        chk("queen_count", last_count, 27);
`ifdef PIECE_MOVE_GEN_ATTACK_MASK_EN
        chk("queen_mask_bits", $countones(attackMask), 27);
`endif

        // Knight held off by a stalled consumer on its first move.
        run_req(4, 4, 0, 3'b010, '0, 100, 5, -1, 0, 0);
        chk("stall_first_valid_cyc", first_valid_cyc, 2);
        chk("stall_first_move", obs_q[0].r * 10 + obs_q[0].c, 23);
        chk("stall_n", obs_q.size(), 8);
        chk("stall_count", last_count, 8);

        // Unsupported type with a start poked while busy.
        run_req(2, 5, 0, 3'b001, '0, 100, 0, -1, 1, 0);
        chk("bad_type_done_cyc", done_cyc, 2);
        chk("bad_type_no_valid", first_valid_cyc, -1);
        chk("bad_type_te", last_te, 1);
        chk("bad_type_count", last_count, 0);

        // Reset during a queen scan, then a clean rerun.
        run_req(3, 3, 0, 3'b101, '0, 100, 0, 6, 0, 0);
        run_req(3, 3, 0, 3'b101, '0, 100, 0, -1, 0, 0);
        chk("after_abort_count", last_count, 27);

        // Random pieces, boards and back-pressure.
        for (int t = 0; t < 60; t++) begin
            bd = '0;
            for (int s = 0; s < N * N; s++) begin
                if ($urandom_range(99) < 30)
                    bd = put(bd, s / N, s % N, 1'($urandom), 3'($urandom));
            end
            run_req($urandom_range(0, 7), $urandom_range(0, 7), 1'($urandom),
                    3'($urandom_range(0, 7)), bd, 60, 0, -1, 0, 0);
        end

        $display("test done: total=%0d bad=%0d", n_tot, n_bad);
        $finish;
    end

endmodule
